// File: rtl/nms_window_stage.sv
// Canny non-maximum suppression: keeps a 3x3 window of gradient magnitudes and
// directions, and emits the thinned centre one cycle after each complete window.
module nms_window_stage #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   shift_enable,
  input  logic [1:0]             shift_direction,
  input  logic [2:0][DATA_W-1:0] mag_in,
  input  logic [2:0][1:0]        dir_in,
  output logic [DATA_W-1:0]      nms_out,
  output logic                   out_valid,
  output logic                   window_full,
  output logic [CNT_W-1:0]       edge_count
);

  // Window indexed [row][col], rows N->S, columns W->E.
  logic [2:0][2:0][DATA_W-1:0] mag_r, mag_nx_s;
  logic [2:0][2:0][1:0]        dir_r, dir_nx_s;
  logic [1:0]                  fill_r, fill_nx_s;
  logic [1:0]                  last_dir_r;
  logic                        accept_s;
  logic                        pend_r;
  logic [DATA_W-1:0]           nms_s;

  // Keep the centre only if it is not smaller than either neighbour along the gradient.
  function automatic logic [DATA_W-1:0] suppress(
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    if ((c >= a) && (c >= b)) begin
      return c;
    end else begin
      return {DATA_W{1'b0}};
    end
  endfunction

  // Next window contents and fill level for the current shift request.
  always_comb begin
    accept_s  = shift_enable && (shift_direction != 2'b00);
    mag_nx_s  = mag_r;
    dir_nx_s  = dir_r;
    fill_nx_s = fill_r;
    if (accept_s) begin
      case (shift_direction)
        2'b01: begin
          mag_nx_s[0] = {mag_in[0], mag_r[0][2], mag_r[0][1]};
          mag_nx_s[1] = {mag_in[1], mag_r[1][2], mag_r[1][1]};
          mag_nx_s[2] = {mag_in[2], mag_r[2][2], mag_r[2][1]};
          dir_nx_s[0] = {dir_in[0], dir_r[0][2], dir_r[0][1]};
          dir_nx_s[1] = {dir_in[1], dir_r[1][2], dir_r[1][1]};
          dir_nx_s[2] = {dir_in[2], dir_r[2][2], dir_r[2][1]};
        end
        2'b10: begin
          mag_nx_s[0] = {mag_r[0][1], mag_r[0][0], mag_in[0]};
          mag_nx_s[1] = {mag_r[1][1], mag_r[1][0], mag_in[1]};
          mag_nx_s[2] = {mag_r[2][1], mag_r[2][0], mag_in[2]};
          dir_nx_s[0] = {dir_r[0][1], dir_r[0][0], dir_in[0]};
          dir_nx_s[1] = {dir_r[1][1], dir_r[1][0], dir_in[1]};
          dir_nx_s[2] = {dir_r[2][1], dir_r[2][0], dir_in[2]};
        end
        2'b11: begin
          mag_nx_s = {mag_in, mag_r[2], mag_r[1]};
          dir_nx_s = {dir_in, dir_r[2], dir_r[1]};
        end
        default: begin
          mag_nx_s = mag_r;
          dir_nx_s = dir_r;
        end
      endcase
      if (shift_direction == last_dir_r) begin
        fill_nx_s = (fill_r == 2'd3) ? 2'd3 : fill_r + 2'd1;
      end else begin
        fill_nx_s = 2'd1;
      end
    end else begin
      mag_nx_s  = mag_r;
      dir_nx_s  = dir_r;
      fill_nx_s = fill_r;
    end
  end

  // Suppression of the registered window along the centre pixel's direction.
  always_comb begin
    nms_s = {DATA_W{1'b0}};
    case (dir_r[1][1])
      2'b00:   nms_s = suppress(mag_r[1][1], mag_r[1][0], mag_r[1][2]);
      2'b01:   nms_s = suppress(mag_r[1][1], mag_r[0][2], mag_r[2][0]);
      2'b10:   nms_s = suppress(mag_r[1][1], mag_r[0][1], mag_r[2][1]);
      2'b11:   nms_s = suppress(mag_r[1][1], mag_r[0][0], mag_r[2][2]);
      default: nms_s = {DATA_W{1'b0}};
    endcase
  end

  // Window, fill tracking and the registered suppression output.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mag_r       <= {(9*DATA_W){1'b0}};
      dir_r       <= {18{1'b0}};
      fill_r      <= 2'd0;
      last_dir_r  <= 2'b00;
      pend_r      <= 1'b0;
      nms_out     <= {DATA_W{1'b0}};
      out_valid   <= 1'b0;
      window_full <= 1'b0;
      edge_count  <= {CNT_W{1'b0}};
    end else begin
      mag_r       <= mag_nx_s;
      dir_r       <= dir_nx_s;
      fill_r      <= fill_nx_s;
      window_full <= (fill_nx_s == 2'd3);
      if (accept_s) begin
        last_dir_r <= shift_direction;
      end
      // pend_r marks that the window now in mag_r is complete and due for output.
      pend_r    <= accept_s && (fill_nx_s == 2'd3);
      out_valid <= pend_r;
      if (pend_r) begin
        nms_out <= nms_s;
        if ((nms_s != {DATA_W{1'b0}}) && (edge_count != {CNT_W{1'b1}})) begin
          edge_count <= edge_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule
